dcache_req_sched: RTL

- Schedules the two LSU data ports (A = older slot, B = younger slot) and the cacop engine onto the single two-lane dcache request port.
- Merges A and B into one dual-lane request when they hit the same cacheable line. Otherwise it splits them over two cycles, A first.
- Tracks in-flight requests in order, so each dcache data_ok is routed back to its owner; flushed requests are discarded.
- Sits between the LSU/EX1 issue logic and the address-translation/dcache front end. It produces handshakes and lane selects only; address and data muxing stays downstream.

---
 rtl/dcache_req_sched.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_req_sched.sv
// Schedules LSU ports A/B and the cacop engine onto the two-lane dcache request port,
// tracking in-flight requests in order. Optional perf counters: define DCACHE_SCHED_PERF_EN.
module dcache_req_sched #(
   parameter int LINE_W    = 28,
   parameter int OST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              a_req,
   input  logic              b_req,
   input  logic [LINE_W-1:0] a_line,
   input  logic [LINE_W-1:0] b_line,
   input  logic              a_uncached,
   input  logic              b_uncached,
   output logic              a_addr_ok,
   output logic              b_addr_ok,
   output logic              a_data_ok,
   output logic              b_data_ok,
   output logic [31:0]       a_rdata,
   output logic [31:0]       b_rdata,
   input  logic              cop_req,
   output logic              cop_ok,
   output logic              dc_p0_valid,
   output logic              dc_p1_valid,
   output logic              dc_p0_is_b,
   output logic              dc_is_cop,
   input  logic              dc_addr_ok,
   input  logic              dc_data_ok,
   input  logic [31:0]       dc_p0_rdata,
   input  logic [31:0]       dc_p1_rdata
`ifdef DCACHE_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_merge_cnt,
   output logic [31:0]       perf_split_cnt,
   output logic [31:0]       perf_full_stall_cnt
`endif
);

   localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, SPLIT_B, COP_DRAIN, COP_ISSUE} state_t;

   typedef struct packed {
      logic a_own;
      logic b_own;
      logic b_lane;
      logic discard;
   } ent_t;

   state_t               state_q, state_d;
   ent_t                 ent_q [OST_DEPTH];
   ent_t                 ent_d [OST_DEPTH];
   logic [OST_DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic full, empty, can_issue, merge_ok;
   logic push, pop;
   ent_t push_ent;
   ent_t head;

   assign full      = (count_q == CNT_W'(OST_DEPTH));
   assign empty     = (count_q == '0);
   assign can_issue = !full && !flush;
   assign merge_ok  = (a_line == b_line) && !a_uncached && !b_uncached;
   assign head      = ent_q[rd_ptr_q];
   assign pop       = dc_data_ok && !empty;

   // Responses: routed by the oldest queue entry; discarded entries are swallowed.
   assign a_data_ok = pop && head.a_own && !head.discard;
   assign b_data_ok = pop && head.b_own && !head.discard;
   assign a_rdata   = dc_p0_rdata;
   assign b_rdata   = head.b_lane ? dc_p1_rdata : dc_p0_rdata;

   always_comb begin
      state_d     = state_q;
      dc_p0_valid = 1'b0;
      dc_p1_valid = 1'b0;
      dc_p0_is_b  = 1'b0;
      dc_is_cop   = 1'b0;
      a_addr_ok   = 1'b0;
      b_addr_ok   = 1'b0;
      cop_ok      = 1'b0;
      push        = 1'b0;
      push_ent    = '0;
      unique case (state_q)
         IDLE: begin
            if (cop_req) begin
               if (!flush) state_d = COP_DRAIN;
            end else if (can_issue) begin
               if (a_req) begin
                  // A always goes on lane 0; B rides lane 1 only for a cacheable same-line pair.
                  dc_p0_valid = 1'b1;
                  dc_p1_valid = b_req && merge_ok;
                  if (dc_addr_ok) begin
                     a_addr_ok      = 1'b1;
                     push           = 1'b1;
                     push_ent.a_own = 1'b1;
                     if (b_req && merge_ok) begin
                        b_addr_ok       = 1'b1;
                        push_ent.b_own  = 1'b1;
                        push_ent.b_lane = 1'b1;
                     end else if (b_req) begin
                        state_d = SPLIT_B;
                     end
                  end
               end else if (b_req) begin
                  dc_p0_valid = 1'b1;
                  dc_p0_is_b  = 1'b1;
                  if (dc_addr_ok) begin
                     b_addr_ok      = 1'b1;
                     push           = 1'b1;
                     push_ent.b_own = 1'b1;
                  end
               end
            end
         end
         SPLIT_B: begin
            if (flush || !b_req) begin
               state_d = IDLE;
            end else if (can_issue) begin
               dc_p0_valid = 1'b1;
               dc_p0_is_b  = 1'b1;
               if (dc_addr_ok) begin
                  b_addr_ok      = 1'b1;
                  push           = 1'b1;
                  push_ent.b_own = 1'b1;
                  state_d        = IDLE;
               end
            end
         end
         COP_DRAIN: begin
            if (flush)      state_d = IDLE;
            else if (empty) state_d = COP_ISSUE;
         end
         COP_ISSUE: begin
            // Once presented, the cacop is held regardless of flush until accepted.
            dc_p0_valid = 1'b1;
            dc_is_cop   = 1'b1;
            if (dc_addr_ok) begin
               cop_ok  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ent_d    = ent_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         ent_d[wr_ptr_q] = push_ent;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      // Flush marks every live entry, including one pushed this cycle.
      if (flush) begin
         for (int i = 0; i < OST_DEPTH; i++) begin
            if (vld_d[i]) ent_d[i].discard = 1'b1;
         end
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < OST_DEPTH; i++) ent_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < OST_DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

`ifdef DCACHE_SCHED_PERF_EN
   logic [31:0] perf_merge_cnt_q, perf_merge_cnt_d;
   logic [31:0] perf_split_cnt_q, perf_split_cnt_d;
   logic [31:0] perf_full_stall_cnt_q, perf_full_stall_cnt_d;
   logic        merge_issue, split_enter, full_stall;

   assign merge_issue = push && push_ent.a_own && push_ent.b_own;
   assign split_enter = (state_q == IDLE) && (state_d == SPLIT_B);
   assign full_stall  = (a_req || b_req) && full;

   // Saturating counters hold at all-ones.
   always_comb begin
      perf_merge_cnt_d      = perf_merge_cnt_q;
      perf_split_cnt_d      = perf_split_cnt_q;
      perf_full_stall_cnt_d = perf_full_stall_cnt_q;
      if (merge_issue && (perf_merge_cnt_q != '1))
         perf_merge_cnt_d = perf_merge_cnt_q + 32'd1;
      if (split_enter && (perf_split_cnt_q != '1))
         perf_split_cnt_d = perf_split_cnt_q + 32'd1;
      if (full_stall && (perf_full_stall_cnt_q != '1))
         perf_full_stall_cnt_d = perf_full_stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_merge_cnt_q      <= '0;
         perf_split_cnt_q      <= '0;
         perf_full_stall_cnt_q <= '0;
      end else begin
         perf_merge_cnt_q      <= perf_merge_cnt_d;
         perf_split_cnt_q      <= perf_split_cnt_d;
         perf_full_stall_cnt_q <= perf_full_stall_cnt_d;
      end
   end

   assign perf_merge_cnt      = perf_merge_cnt_q;
   assign perf_split_cnt      = perf_split_cnt_q;
   assign perf_full_stall_cnt = perf_full_stall_cnt_q;
`endif

endmodule
